// File: rtl/mips_mc_control_pkg.sv
// Shared encodings for the multicycle MIPS controller, datapath and ALU:
// FSM states, opcode/funct values, ALU codes and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTE,
    S_ALUWB,
    S_IMMEX,
    S_IMMWB,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_JR,
    S_TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4;
  localparam logic [4:0] ALU_SLL = 5'd5;
  localparam logic [4:0] ALU_SRL = 5'd6;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
  localparam logic [1:0] MEMTOREG_DATA   = 2'b01;
  localparam logic [1:0] MEMTOREG_PC     = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHAMT = 2'b11;

  localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
  localparam logic [1:0] PCSRC_JUMP      = 2'b10;
  localparam logic [1:0] PCSRC_REG       = 2'b11;

endpackage

// File: rtl/mips_mc_control_if.sv
// Control bundle between the multicycle controller (master) and the
// datapath/memory side (slave).
interface mips_mc_control_if #(
  parameter int OP_WIDTH = 6
);
  logic [OP_WIDTH-1:0] Op;
  logic [OP_WIDTH-1:0] Funct;
  logic                Zero;
  logic                MemReady;

  logic       PCen;
  logic       IorD;
  logic       MemReq;
  logic       MemWrite;
  logic       IRWrite;
  logic       DRWrite;
  logic       RegWrite;
  logic       ALUSrcA;
  logic       ALU_en;
  logic       Page;
  logic       SerialOutEn;
  logic       Illegal;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcB;
  logic [4:0] ALUControl;
  logic [1:0] PCSrc;

  modport master (
    input  Op, Funct, Zero, MemReady,
    output PCen, IorD, MemReq, MemWrite, IRWrite, DRWrite, RegWrite,
           ALUSrcA, ALU_en, Page, SerialOutEn, Illegal,
           RegDst, MemtoReg, ALUSrcB, ALUControl, PCSrc
  );

  modport slave (
    output Op, Funct, Zero, MemReady,
    input  PCen, IorD, MemReq, MemWrite, IRWrite, DRWrite, RegWrite,
           ALUSrcA, ALU_en, Page, SerialOutEn, Illegal,
           RegDst, MemtoReg, ALUSrcB, ALUControl, PCSrc
  );
endinterface

// File: rtl/mips_mc_control_alu_decoder.sv
// R-type funct decoder: ALU operation, shift-amount operand select, and
// whether the funct is one this core executes.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [4:0] alu_control,
  output logic       shift,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    shift       = 1'b0;
    legal       = 1'b1;
    case (funct)
      FN_ADD: alu_control = ALU_ADD;
      FN_SUB: alu_control = ALU_SUB;
      FN_AND: alu_control = ALU_AND;
      FN_OR:  alu_control = ALU_OR;
      FN_SLT: alu_control = ALU_SLT;
      FN_SLL: begin
        alu_control = ALU_SLL;
        shift       = 1'b1;
      end
      FN_SRL: begin
        alu_control = ALU_SRL;
        shift       = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Moore multicycle controller for the MIPS core with a variable-latency memory
// handshake. Define MIPS_JUMP_LINK_EN to add jal/jr; otherwise they trap.
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 6
) (
  input  logic              clk,
  input  logic              reset,
  mips_mc_control_if.master ctl
);

  if (DATA_WIDTH < 32) begin : g_width_check
    $error("mips_mc_control: DATA_WIDTH must be at least 32");
  end

  state_e     state_q, state_d;
  logic [4:0] fn_alu_control;
  logic       fn_shift;
  logic       fn_legal;

  mips_alu_decoder u_alu_decoder (
    .funct       (ctl.Funct[5:0]),
    .alu_control (fn_alu_control),
    .shift       (fn_shift),
    .legal       (fn_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (ctl.MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (ctl.Op)
          OP_LW, OP_SW:    state_d = S_MEMADR;
`ifdef MIPS_JUMP_LINK_EN
          OP_RTYPE:        state_d = (ctl.Funct == FN_JR) ? S_JR : S_EXECUTE;
          OP_JAL:          state_d = S_JAL;
`else
          OP_RTYPE:        state_d = S_EXECUTE;
          OP_JAL:          state_d = S_TRAP;
`endif
          OP_ADDI, OP_ORI: state_d = S_IMMEX;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (ctl.Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (ctl.MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (ctl.MemReady) state_d = S_FETCH;
      // Unknown funct is only detected here, after decode has dispatched.
      S_EXECUTE:  state_d = fn_legal ? S_ALUWB : S_TRAP;
      S_ALUWB:    state_d = S_FETCH;
      S_IMMEX:    state_d = S_IMMWB;
      S_IMMWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_JAL:      state_d = S_FETCH;
      S_JR:       state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctl.PCen        = 1'b0;
    ctl.IorD        = 1'b0;
    ctl.MemReq      = 1'b0;
    ctl.MemWrite    = 1'b0;
    ctl.IRWrite     = 1'b0;
    ctl.DRWrite     = 1'b0;
    ctl.RegWrite    = 1'b0;
    ctl.ALUSrcA     = 1'b0;
    ctl.ALU_en      = 1'b0;
    ctl.Page        = 1'b0;
    ctl.SerialOutEn = 1'b0;
    ctl.Illegal     = 1'b0;
    ctl.RegDst      = REGDST_RT;
    ctl.MemtoReg    = MEMTOREG_ALUOUT;
    ctl.ALUSrcB     = SRCB_B;
    ctl.ALUControl  = ALU_ADD;
    ctl.PCSrc       = PCSRC_ALURESULT;
    case (state_q)
      S_FETCH: begin
        ctl.MemReq  = 1'b1;
        ctl.ALUSrcB = SRCB_ONE;
        ctl.IRWrite = ctl.MemReady;
        ctl.PCen    = ctl.MemReady;
      end
      S_DECODE: begin
        ctl.ALUSrcB = SRCB_IMM;
        ctl.ALU_en  = 1'b1;
      end
      S_MEMADR: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUSrcB = SRCB_IMM;
        ctl.ALU_en  = 1'b1;
      end
      S_MEMREAD: begin
        ctl.MemReq  = 1'b1;
        ctl.IorD    = 1'b1;
        ctl.Page    = 1'b1;
        ctl.DRWrite = ctl.MemReady;
      end
      S_MEMWB: begin
        ctl.RegWrite = 1'b1;
        ctl.MemtoReg = MEMTOREG_DATA;
      end
      S_MEMWRITE: begin
        ctl.MemReq   = 1'b1;
        ctl.MemWrite = 1'b1;
        ctl.IorD     = 1'b1;
        ctl.Page     = 1'b1;
      end
      S_EXECUTE: begin
        ctl.ALUSrcA    = 1'b1;
        ctl.ALU_en     = 1'b1;
        ctl.ALUControl = fn_alu_control;
        ctl.ALUSrcB    = fn_shift ? SRCB_SHAMT : SRCB_B;
      end
      S_ALUWB, S_IMMWB: begin
        ctl.RegWrite    = 1'b1;
        ctl.RegDst      = (state_q == S_ALUWB) ? REGDST_RD : REGDST_RT;
        ctl.SerialOutEn = 1'b1;
      end
      S_IMMEX: begin
        ctl.ALUSrcA    = 1'b1;
        ctl.ALUSrcB    = SRCB_IMM;
        ctl.ALUControl = (ctl.Op == OP_ORI) ? ALU_OR : ALU_ADD;
        ctl.ALU_en     = 1'b1;
      end
      // ALU_en stays low so ALUout keeps the branch target computed in decode.
      S_BRANCH: begin
        ctl.ALUSrcA    = 1'b1;
        ctl.ALUControl = ALU_SUB;
        ctl.PCSrc      = PCSRC_ALUOUT;
        ctl.PCen       = (ctl.Op == OP_BNE) ? !ctl.Zero : ctl.Zero;
      end
      S_JUMP: begin
        ctl.PCen  = 1'b1;
        ctl.PCSrc = PCSRC_JUMP;
      end
`ifdef MIPS_JUMP_LINK_EN
      S_JAL: begin
        ctl.RegWrite = 1'b1;
        ctl.RegDst   = REGDST_RA;
        ctl.MemtoReg = MEMTOREG_PC;
        ctl.PCen     = 1'b1;
        ctl.PCSrc    = PCSRC_JUMP;
      end
      S_JR: begin
        ctl.PCen  = 1'b1;
        ctl.PCSrc = PCSRC_REG;
      end
`endif
      S_TRAP:  ctl.Illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed scoreboard bench for mips_mc_control: every cycle queues the
// expected control word and compares it against the DUT just after the edge.
module tb_mips_mc_control;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memreq;
    logic       memwrite;
    logic       irwrite;
    logic       drwrite;
    logic       regwrite;
    logic       alusrca;
    logic       alu_en;
    logic       page;
    logic       serial;
    logic       illegal;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] alusrcb;
    logic [4:0] aluctl;
    logic [1:0] pcsrc;
  } ctl_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mips_mc_control_if #(.OP_WIDTH(6)) bus ();

  mips_mc_control #(
    .DATA_WIDTH (32),
    .OP_WIDTH   (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bus.master)
  );

  always #5 clk = ~clk;

  ctl_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam ctl_t Z = '0;

  logic [5:0] r_funct [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b101010, 6'b000000, 6'b000010};
  logic [4:0] r_code  [7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
  logic       r_shift [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  logic [5:0] b_op   [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
  logic       b_zero [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic       b_take [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  function automatic ctl_t observe();
    ctl_t o;
    o.pcen     = bus.PCen;
    o.iord     = bus.IorD;
    o.memreq   = bus.MemReq;
    o.memwrite = bus.MemWrite;
    o.irwrite  = bus.IRWrite;
    o.drwrite  = bus.DRWrite;
    o.regwrite = bus.RegWrite;
    o.alusrca  = bus.ALUSrcA;
    o.alu_en   = bus.ALU_en;
    o.page     = bus.Page;
    o.serial   = bus.SerialOutEn;
    o.illegal  = bus.Illegal;
    o.regdst   = bus.RegDst;
    o.memtoreg = bus.MemtoReg;
    o.alusrcb  = bus.ALUSrcB;
    o.aluctl   = bus.ALUControl;
    o.pcsrc    = bus.PCSrc;
    return o;
  endfunction

  function automatic ctl_t e_fetch(logic ready);
    ctl_t c = '0;
    c.memreq = 1'b1; c.alusrcb = 2'b01; c.irwrite = ready; c.pcen = ready;
    return c;
  endfunction

  function automatic ctl_t e_decode();
    ctl_t c = '0;
    c.alusrcb = 2'b10; c.alu_en = 1'b1;
    return c;
  endfunction

  function automatic ctl_t e_memadr();
    ctl_t c = '0;
    c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alu_en = 1'b1;
    return c;
  endfunction

  function automatic ctl_t e_memread(logic ready);
    ctl_t c = '0;
    c.memreq = 1'b1; c.iord = 1'b1; c.page = 1'b1; c.drwrite = ready;
    return c;
  endfunction

  function automatic ctl_t e_memwb();
    ctl_t c = '0;
    c.regwrite = 1'b1; c.memtoreg = 2'b01;
    return c;
  endfunction

  function automatic ctl_t e_memwrite();
    ctl_t c = '0;
    c.memreq = 1'b1; c.memwrite = 1'b1; c.iord = 1'b1; c.page = 1'b1;
    return c;
  endfunction

  function automatic ctl_t e_exec(logic [4:0] code, logic shift);
    ctl_t c = '0;
    c.alusrca = 1'b1; c.alu_en = 1'b1; c.aluctl = code;
    c.alusrcb = shift ? 2'b11 : 2'b00;
    return c;
  endfunction

  function automatic ctl_t e_wb(logic rd);
    ctl_t c = '0;
    c.regwrite = 1'b1; c.serial = 1'b1; c.regdst = rd ? 2'b01 : 2'b00;
    return c;
  endfunction

  function automatic ctl_t e_immex(logic [4:0] code);
    ctl_t c = '0;
    c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluctl = code; c.alu_en = 1'b1;
    return c;
  endfunction

  function automatic ctl_t e_branch(logic take);
    ctl_t c = '0;
    c.alusrca = 1'b1; c.aluctl = 5'd1; c.pcsrc = 2'b01; c.pcen = take;
    return c;
  endfunction

  function automatic ctl_t e_jump();
    ctl_t c = '0;
    c.pcen = 1'b1; c.pcsrc = 2'b10;
    return c;
  endfunction

  function automatic ctl_t e_trap();
    ctl_t c = '0;
    c.illegal = 1'b1;
    return c;
  endfunction

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                               input logic zero, input logic ready,
                               input ctl_t expv);
    bus.Op       = op;
    bus.Funct    = funct;
    bus.Zero     = zero;
    bus.MemReady = ready;
    exp_q.push_back(expv);
  endtask

  task automatic checkOutput(input string tag);
    ctl_t e;
    ctl_t o;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: observed a DUT output with no queued expectation", tag);
    end else begin
      e = exp_q.pop_front();
      o = observe();
      assert (o === e) else begin
        errors++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, o, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input string tag, input logic [5:0] op,
                      input logic [5:0] funct, input logic zero,
                      input logic ready, input ctl_t expv);
    applyStimulus(op, funct, zero, ready, expv);
    checkOutput(tag);
  endtask

  task automatic doReset(input string tag);
    reset = 1'b1;
    step(tag, 6'b0, 6'b0, 1'b0, 1'b1, Z);
    reset = 1'b0;
    step("idle", 6'b0, 6'b0, 1'b0, 1'b1, Z);
  endtask

  initial begin
    bus.Op = '0; bus.Funct = '0; bus.Zero = 1'b0; bus.MemReady = 1'b0;
    @(negedge clk);
    doReset("reset_hold");

    step("add_fetch",  6'b000000, 6'b100000, 1'b0, 1'b1, e_fetch(1'b1));
    step("add_decode", 6'b000000, 6'b100000, 1'b0, 1'b1, e_decode());
    step("add_exec",   6'b000000, 6'b100000, 1'b0, 1'b1, e_exec(5'd0, 1'b0));
    step("add_wb",     6'b000000, 6'b100000, 1'b0, 1'b1, e_wb(1'b1));

    for (int i = 0; i < 2; i++)
      step("lw_fetch_wait", 6'b100011, 6'b0, 1'b0, 1'b0, e_fetch(1'b0));
    step("lw_fetch",   6'b100011, 6'b0, 1'b0, 1'b1, e_fetch(1'b1));
    step("lw_decode",  6'b100011, 6'b0, 1'b0, 1'b0, e_decode());
    step("lw_memadr",  6'b100011, 6'b0, 1'b0, 1'b1, e_memadr());
    for (int i = 0; i < 2; i++)
      step("lw_read_wait", 6'b100011, 6'b0, 1'b0, 1'b0, e_memread(1'b0));
    step("lw_read",    6'b100011, 6'b0, 1'b0, 1'b1, e_memread(1'b1));
    step("lw_wb",      6'b100011, 6'b0, 1'b0, 1'b1, e_memwb());

    step("sw_fetch",      6'b101011, 6'b0, 1'b0, 1'b1, e_fetch(1'b1));
    step("sw_decode",     6'b101011, 6'b0, 1'b0, 1'b1, e_decode());
    step("sw_memadr",     6'b101011, 6'b0, 1'b0, 1'b1, e_memadr());
    step("sw_write_wait", 6'b101011, 6'b0, 1'b0, 1'b0, e_memwrite());
    step("sw_write",      6'b101011, 6'b0, 1'b0, 1'b1, e_memwrite());

    step("ori_fetch",  6'b001101, 6'b0, 1'b0, 1'b1, e_fetch(1'b1));
    step("ori_decode", 6'b001101, 6'b0, 1'b0, 1'b1, e_decode());
    step("ori_immex",  6'b001101, 6'b0, 1'b0, 1'b1, e_immex(5'd3));
    step("ori_wb",     6'b001101, 6'b0, 1'b0, 1'b1, e_wb(1'b0));

    step("addi_fetch",  6'b001000, 6'b0, 1'b0, 1'b1, e_fetch(1'b1));
    step("addi_decode", 6'b001000, 6'b0, 1'b0, 1'b1, e_decode());
    step("addi_immex",  6'b001000, 6'b0, 1'b0, 1'b1, e_immex(5'd0));
    step("addi_wb",     6'b001000, 6'b0, 1'b0, 1'b1, e_wb(1'b0));

    for (int i = 0; i < 7; i++) begin
      step("r_fetch",  6'b000000, r_funct[i], 1'b0, 1'b1, e_fetch(1'b1));
      step("r_decode", 6'b000000, r_funct[i], 1'b0, 1'b1, e_decode());
      step("r_exec",   6'b000000, r_funct[i], 1'b0, 1'b1, e_exec(r_code[i], r_shift[i]));
      step("r_wb",     6'b000000, r_funct[i], 1'b0, 1'b1, e_wb(1'b1));
    end

    for (int i = 0; i < 4; i++) begin
      step("br_fetch",  b_op[i], 6'b0, b_zero[i], 1'b1, e_fetch(1'b1));
      step("br_decode", b_op[i], 6'b0, b_zero[i], 1'b1, e_decode());
      step("br_branch", b_op[i], 6'b0, b_zero[i], 1'b1, e_branch(b_take[i]));
    end

    step("j_fetch",  6'b000010, 6'b0, 1'b0, 1'b1, e_fetch(1'b1));
    step("j_decode", 6'b000010, 6'b0, 1'b0, 1'b1, e_decode());
    step("j_jump",   6'b000010, 6'b0, 1'b0, 1'b1, e_jump());
    step("after_j_fetch", 6'b000000, 6'b100000, 1'b0, 1'b0, e_fetch(1'b0));
    step("after_j_fetch", 6'b000000, 6'b100000, 1'b0, 1'b1, e_fetch(1'b1));
    step("after_j_decode", 6'b000000, 6'b100000, 1'b0, 1'b1, e_decode());
    step("after_j_exec", 6'b000000, 6'b100000, 1'b0, 1'b1, e_exec(5'd0, 1'b0));
    step("after_j_wb", 6'b000000, 6'b100000, 1'b0, 1'b1, e_wb(1'b1));

    step("jr_fetch",  6'b000000, 6'b001000, 1'b0, 1'b1, e_fetch(1'b1));
    step("jr_decode", 6'b000000, 6'b001000, 1'b0, 1'b1, e_decode());
`ifdef MIPS_JUMP_LINK_EN
    begin
      ctl_t c = '0;
      c.pcen = 1'b1; c.pcsrc = 2'b11;
      step("jr_jr", 6'b000000, 6'b001000, 1'b0, 1'b1, c);
      step("jr_next_fetch", 6'b000000, 6'b001000, 1'b0, 1'b0, e_fetch(1'b0));
    end
`else
    step("jr_exec", 6'b000000, 6'b001000, 1'b0, 1'b1, e_exec(5'd0, 1'b0));
    step("jr_trap", 6'b000000, 6'b001000, 1'b0, 1'b1, e_trap());
`endif
    doReset("reset_after_jr");

    step("ill_fetch",  6'b111111, 6'b0, 1'b0, 1'b1, e_fetch(1'b1));
    step("ill_decode", 6'b111111, 6'b0, 1'b0, 1'b1, e_decode());
    for (int i = 0; i < 12; i++)
      step("ill_trap_hold", 6'b000000, 6'b100000, 1'b1, 1'b1, e_trap());
    doReset("trap_clear");

    step("mid_fetch_wait", 6'b000000, 6'b0, 1'b0, 1'b0, e_fetch(1'b0));
    doReset("reset_mid_access");

    step("jal_fetch",  6'b000011, 6'b0, 1'b0, 1'b1, e_fetch(1'b1));
    step("jal_decode", 6'b000011, 6'b0, 1'b0, 1'b1, e_decode());
`ifdef MIPS_JUMP_LINK_EN
    begin
      ctl_t c = '0;
      c.regwrite = 1'b1; c.regdst = 2'b10; c.memtoreg = 2'b10;
      c.pcen = 1'b1; c.pcsrc = 2'b10;
      step("jal_jal", 6'b000011, 6'b0, 1'b0, 1'b1, c);
      step("jal_next_fetch", 6'b000011, 6'b0, 1'b0, 1'b0, e_fetch(1'b0));
    end
`else
    step("jal_trap", 6'b000011, 6'b0, 1'b0, 1'b1, e_trap());
    step("jal_trap_hold", 6'b000011, 6'b0, 1'b0, 1'b1, e_trap());
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Parametrised multicycle control unit for the MIPS core. It is the next generation of the core's controller. It sequences fetch, decode, execute, memory and writeback through a Moore state machine. Unlike the fixed-latency controller, it supports a variable-latency memory handshake (`MemReq`/`MemReady`), `bne`, `j`, shift instructions, an illegal-instruction trap, and optional `jal`/`jr`. It sits between the instruction register (`Op`/`Funct`), the ALU zero flag, and every datapath enable/mux select of the multicycle MIPS top level.

## Interface
- `DATA_WIDTH`, 32, datapath word length; checked for ≥ 32; does not change control behaviour.
- `OP_WIDTH`, 6, opcode/funct field width.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `Op` in `OP_WIDTH`: `Instr[31:26]`.
- `Funct` in `OP_WIDTH`: `Instr[5:0]`.
- `Zero` in 1: ALU result == 0.
- `MemReady` in 1: memory completes the current request this cycle.
- `PCen`, `IorD`, `MemReq`, `MemWrite`, `IRWrite`, `DRWrite`, `RegWrite`, `ALUSrcA`, `ALU_en`, `Page`, `SerialOutEn`, `Illegal` out 1 each.
- `RegDst` out 2: 00 = rt, 01 = rd, 10 = r31.
- `MemtoReg` out 2: 00 = ALUout, 01 = Data, 10 = PC.
- `ALUSrcB` out 2: 00 = B, 01 = 1, 10 = SignImm, 11 = shamt.
- `ALUControl` out 5.
- `PCSrc` out 2: 00 = ALUResult, 01 = ALUout, 10 = jump target, 11 = A.

## Operation
- Outputs are decoded from the registered state. `MemReady` and `Zero` gate only the listed strobes.
- Unlisted outputs are 0 in each state.
- **IDLE** (entered on reset): all outputs 0. Goes to FETCH unconditionally next cycle.
- **FETCH**:
  - Drives `MemReq` = 1, `IorD` = 0, `Page` = 0, `ALUSrcA` = 0, `ALUSrcB` = 01, ADD.
  - `IRWrite` = `PCen` = `MemReady`, with `PCSrc` = 00.
  - Moves to DECODE on `MemReady`, else holds.
- **DECODE**: `ALUSrcA` = 0, `ALUSrcB` = 10, ADD, `ALU_en` = 1 (computes branch target). Dispatches on `Op`:
  - lw/sw → MEMADR
  - R-type → EXECUTE
  - addi/ori → IMMEX
  - beq/bne → BRANCH
  - j → JUMP
  - jal → JAL, or R-type with funct `jr` → JR (both only with the macro)
  - anything else → TRAP
- **MEMADR**: `ALUSrcA` = 1, `ALUSrcB` = 10, ADD, `ALU_en`. lw → MEMREAD, sw → MEMWRITE.
- **MEMREAD**: `MemReq`, `IorD` = 1, `Page` = 1, `DRWrite` = `MemReady`. Moves to MEMWB on `MemReady`.
- **MEMWB**: `RegWrite`, `RegDst` = 00, `MemtoReg` = 01. Goes to FETCH.
- **MEMWRITE**: `MemReq`, `MemWrite`, `IorD` = 1, `Page` = 1, all held until `MemReady`. Goes to FETCH on `MemReady`.
- **EXECUTE**: `ALUSrcA` = 1, `ALU_en`, `ALUControl` from funct. `ALUSrcB` = 11 for sll/srl, else 00. Unknown funct → TRAP. Goes to ALUWB.
- **ALUWB**: `RegWrite`, `RegDst` = 01, `MemtoReg` = 00, `SerialOutEn` = 1. Goes to FETCH.
- **IMMEX**: `ALUSrcA` = 1, `ALUSrcB` = 10, ADD (addi) or OR (ori), `ALU_en`. Goes to IMMWB.
- **IMMWB**: as ALUWB but `RegDst` = 00. Goes to FETCH.
- **BRANCH**:
  - `ALUSrcA` = 1, `ALUSrcB` = 00, SUB, `ALU_en` = 0 (target held in ALUout), `PCSrc` = 01.
  - `PCen` = `Zero` for beq, `!Zero` for bne.
  - Goes to FETCH.
- **JUMP**: `PCen` = 1, `PCSrc` = 10. Goes to FETCH.
- **TRAP**: all outputs 0 except `Illegal` = 1. Sticky until reset.
- **ALU codes**: ADD = 0, SUB = 1, AND = 2, OR = 3, SLT = 4, SLL = 5, SRL = 6.
- **Opcodes**: R = 000000, addi = 001000, ori = 001101, lw = 100011, sw = 101011, beq = 000100, bne = 000101, j = 000010, jal = 000011.
- **Funct**: add = 100000, sub = 100010, and = 100100, or = 100101, slt = 101010, sll = 000000, srl = 000010, jr = 001000.

## Timing
- Reset is asynchronous: the state goes to IDLE immediately and all outputs read 0 while `reset` is high.
- Reset asserted mid-access drops `MemReq` the same cycle. Memory must abort the access.
- Cycle counts with zero wait states (`MemReady` high on first request cycle):
  - R-type / immediate: 4
  - lw: 5
  - sw: 4
  - beq/bne/j: 3
- Each wait cycle adds exactly one cycle per memory state.
- `MemReq`, `IorD`, `Page` and `MemWrite` stay stable from the first request cycle through the `MemReady` cycle.
- `MemReady` outside FETCH/MEMREAD/MEMWRITE is ignored.
- `IRWrite`, `DRWrite` and the fetch `PCen` are each single-cycle strobes.
- `SerialOutEn` pulses exactly once per ALU or immediate instruction.

## Configuration
- Macro: `MIPS_JUMP_LINK_EN`.
- **Defined**:
  - **JAL** state: `RegWrite`, `RegDst` = 10, `MemtoReg` = 10, `PCen` = 1, `PCSrc` = 10, all in one cycle. The register file captures the pre-update PC (already PC+1). Goes to FETCH.
  - **JR** state: `PCen` = 1, `PCSrc` = 11. Goes to FETCH.
- **Undefined**: jal and jr decode as illegal → TRAP.
- `RegDst` = 10 and `PCSrc` = 11 are never driven.

## Structure
- Package `mips_ctrl_pkg` holds:
  - state enum
  - opcode and funct localparams
  - ALU code localparams
  - `RegDst`, `MemtoReg`, `ALUSrcB` and `PCSrc` encodings

  The datapath and ALU share these.
- One sub-module, `mips_alu_decoder`: combinational funct → {`ALUControl`, shift flag, legal flag}.

## Test plan
- **Reset and idle**: `reset` pulse → all outputs 0 during reset and for the IDLE cycle. `MemReq` = 1 on the next cycle.
- **add, zero wait states**: `Op` = 0, `Funct` = 100000, `MemReady` = 1 → states FETCH, DECODE, EXECUTE, ALUWB. `RegWrite` = 1 and `RegDst` = 01 in cycle 4; `SerialOutEn` one pulse.
- **lw with 2 wait states**: `MemReady` low for 2 cycles in FETCH and in MEMREAD → 9 cycles total. `DRWrite` exactly on the `MemReady` cycle; `Page` = 1 in MEMREAD.
- **beq/bne**: beq with `Zero` = 1 → `PCen` = 1, `PCSrc` = 01. bne with `Zero` = 1 → `PCen` = 0. Both take 3 cycles.
- **Illegal opcode**: `Op` = 111111 → TRAP with `Illegal` = 1 held for 10+ cycles. Reset clears it.
- **jal (macro on)**: `Op` = 000011 → JAL cycle with `RegWrite` = 1, `RegDst` = 10, `MemtoReg` = 10, `PCen` = 1, `PCSrc` = 10. With the macro off → TRAP.
